product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulator that sits directly downstream of the 3-bit multiplier array. It consumes the 6-bit products and sums a frame of LEN products, or fewer if the frame is flushed early. It presents the frame total through a valid/ready output handshake. It is the first clocked stage of the multiply-accumulate datapath.

## Interface
- `ACC_W`, default 10: accumulator/result width; must be ≥ 6.
- `LEN`, default 4: products per frame; legal range 1..255.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `p_in` holds a valid product.
- `in_ready`  out  1: block accepts a product this cycle.
- `p_in`  in  6: unsigned product, 0..49 from the 3x3 multiplier; full 0..63 must be handled.
- `flush`  in  1: end the current frame early.
- `out_valid`  out  1: frame result available.
- `out_ready`  in  1: consumer takes the result.
- `acc_out`  out  ACC_W: frame sum, modulo 2^ACC_W.
- `cnt_out`  out  8: number of products in the frame.
- `ovf`  out  1: the frame sum exceeded 2^ACC_W − 1.

## Operation
- States: `ACCUM` and `HOLD`. Reset puts the block in `ACCUM` with acc=0, cnt=0, ovf=0.
- Reset values of the outputs: `in_ready`=1, `out_valid`=0, `acc_out`=0, `cnt_out`=0, `ovf`=0.
- `in_ready` = (state==`ACCUM`). `out_valid` = (state==`HOLD`).
- Accept rule: a product is accepted when `in_valid` & `in_ready` at a rising edge.
  - On accept: acc ← acc + zero-extended `p_in` (wraps modulo 2^ACC_W).
  - On accept: cnt ← cnt+1.
  - On accept: ovf ← ovf | carry-out of the add.
- `ACCUM`→`HOLD` on either of these events:
  - an accept with cnt==LEN−1;
  - `flush`=1 with cnt>0.
- `flush` and accept in the same cycle: the product is included, then the frame closes.
- `flush` with cnt==0 and no accept: ignored.
- `HOLD`: `acc_out`, `cnt_out` and `ovf` are frozen and `p_in` is ignored.
- `HOLD`→`ACCUM` when `out_ready`=1. On that edge acc, cnt and ovf clear to 0.
- `flush` is ignored in `HOLD`.
- `acc_out`, `cnt_out` and `ovf` directly reflect the acc, cnt and ovf registers in both states.
- `rst` mid-frame or in `HOLD`: immediate return to the reset values. The partial sum is discarded and no result is emitted.

## Timing
- Latency: the last accept at edge k gives `out_valid`=1 from edge k onward, with `acc_out` already including that product. Latency is 1 cycle.
- Output handshake completes at the first edge where `out_valid` & `out_ready`. `in_ready` rises immediately after that edge.
- Throughput is one bubble cycle per frame: LEN accepts plus at least 1 `HOLD` cycle.
- `out_ready` high before `out_valid` is allowed and has no effect.
- `out_valid` stays high with stable data until the handshake completes.
- No combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `mul_pkg`:
  - state enum `ACCUM`/`HOLD`;
  - constant `PROD_W`=6;
  - constant `CNT_W`=8.
- One sub-module, `frame_counter`: 8-bit count with `inc`, `clr` and a terminal flag `last` = (cnt==LEN−1).
- Accumulator register, overflow flag and FSM live in the top level.

## Test plan
- LEN=4, products 49,49,49,49 back-to-back → `acc_out`=196, `cnt_out`=4, `ovf`=0, `out_valid` 1 cycle after the 4th accept.
- ACC_W=8, LEN=6, six products of 49 → `acc_out`=38 (294 mod 256), `ovf`=1. After the handshake, the next frame starts with ovf=0.
- LEN=4, products 5 then 7, then `flush` in an idle cycle → `acc_out`=12, `cnt_out`=2. `flush` together with a third accept of 9 → `acc_out`=21, `cnt_out`=3.
- Backpressure: hold `out_ready`=0 for 5 cycles in `HOLD` while driving `in_valid`=1 with 63.
  - Required: `in_ready`=0, result stable, no product absorbed.
  - After `out_ready`=1: the next frame begins at 0.
- Assert `rst` asynchronously after 2 accepts (values 10, 20) → all outputs return to reset values without waiting for a clock edge. The next frame of 1,2,3,4 yields 10.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and widths for the multiply-accumulate datapath
package mul_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} acc_state_e;
  localparam int PROD_W = 6;
  localparam int CNT_W = 8;
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input and frame-result handshake bundle
interface product_accumulator_if import mul_pkg::*; #(parameter int ACC_W = 10);
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] p_in;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] cnt_out;
  logic ovf;
  modport master (output in_valid, p_in, flush, out_ready, input in_ready, out_valid, acc_out, cnt_out, ovf);
  modport slave (input in_valid, p_in, flush, out_ready, output in_ready, out_valid, acc_out, cnt_out, ovf);
endinterface

// File: rtl/product_accumulator_frame_counter.sv
// frame_counter: products-in-frame count with terminal flag
module frame_counter import mul_pkg::*; #(parameter int LEN = 4) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic last_o
);
  logic [CNT_W-1:0] cnt_q;
  // clear wins over increment
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  assign last_o = cnt_q == CNT_W'(LEN - 1);
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums frames of products and hands out each total
module product_accumulator import mul_pkg::*; #(
  parameter int ACC_W = 10,
  parameter int LEN = 4
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  acc_state_e state_q;
  logic [ACC_W-1:0] acc_q;
  logic ovf_q;
  logic [CNT_W-1:0] cnt;
  logic last, accept, close, release_frame;
  logic [ACC_W:0] sum;
  assign accept = bus.in_valid && state_q == ACCUM;
  assign release_frame = state_q == HOLD && bus.out_ready;
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.p_in};
  // a flush on an empty frame only closes it if a product lands in the same cycle
  assign close = (accept && last) || (state_q == ACCUM && bus.flush && (cnt != '0 || accept));
  frame_counter #(.LEN(LEN)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc_i(accept),
    .clr_i(release_frame),
    .cnt_o(cnt),
    .last_o(last)
  );
  // frame FSM with accumulator and sticky overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ACCUM;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (release_frame) begin
      state_q <= ACCUM;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= close ? HOLD : state_q;
      acc_q <= accept ? sum[ACC_W-1:0] : acc_q;
      ovf_q <= ovf_q | (accept & sum[ACC_W]);
    end
  assign bus.in_ready = state_q == ACCUM;
  assign bus.out_valid = state_q == HOLD;
  assign bus.acc_out = acc_q;
  assign bus.cnt_out = cnt;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: two configurations driven in lockstep against a frame-level model
module tb_product_accumulator;
  logic clk = 0, rst = 1;
  logic in_valid = 0, flush = 0, out_ready = 0;
  logic [5:0] p_in = 0;
  int vectors = 0, miscompares = 0;
  int lw[2] = '{10, 8};
  int ll[2] = '{4, 6};
  int m_sum[2], m_cnt[2];
  bit m_hold[2];
  always #5 clk = ~clk;
  product_accumulator_if #(.ACC_W(10)) if0 ();
  product_accumulator_if #(.ACC_W(8)) if1 ();
  assign if0.in_valid = in_valid;
  assign if0.p_in = p_in;
  assign if0.flush = flush;
  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;
  assign if1.p_in = p_in;
  assign if1.flush = flush;
  assign if1.out_ready = out_ready;
  product_accumulator #(.ACC_W(10), .LEN(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  product_accumulator #(.ACC_W(8), .LEN(6)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
    end
  endtask
  // frame-level model: a frame is the list of products taken since the last release
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
      end else if (!m_hold[i]) begin
        if (in_valid) begin
          m_sum[i] += p_in;
          m_cnt[i]++;
        end
        if ((in_valid && m_cnt[i] == ll[i]) || (flush && m_cnt[i] > 0)) m_hold[i] = 1;
      end else if (out_ready) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
      end
  always @(negedge clk) begin
    chk("rdy0", if0.in_ready, !m_hold[0]);
    chk("vld0", if0.out_valid, m_hold[0]);
    chk("acc0", if0.acc_out, m_sum[0] % (1 << lw[0]));
    chk("cnt0", if0.cnt_out, m_cnt[0]);
    chk("ovf0", if0.ovf, m_sum[0] >= (1 << lw[0]));
    chk("rdy1", if1.in_ready, !m_hold[1]);
    chk("vld1", if1.out_valid, m_hold[1]);
    chk("acc1", if1.acc_out, m_sum[1] % (1 << lw[1]));
    chk("cnt1", if1.cnt_out, m_cnt[1]);
    chk("ovf1", if1.ovf, m_sum[1] >= (1 << lw[1]));
  end
  task automatic cyc(input logic v, input logic [5:0] p, input logic f, input logic r);
    in_valid = v; p_in = p; flush = f; out_ready = r;
    @(posedge clk); #1;
  endtask
  initial begin
    #1;
    chk("reset_rdy", if0.in_ready, 1);
    chk("reset_vld", if0.out_valid, 0);
    chk("reset_acc", if0.acc_out, 0);
    #12 rst = 0;
    @(posedge clk); #1;
    repeat (3) cyc(1, 49, 0, 0);
    chk("pre4_vld", if0.out_valid, 0);
    cyc(1, 49, 0, 0);
    chk("f49_vld", if0.out_valid, 1);
    chk("f49_acc", if0.acc_out, 196);
    chk("f49_cnt", if0.cnt_out, 4);
    chk("f49_ovf", if0.ovf, 0);
    repeat (2) cyc(1, 49, 0, 0);
    chk("f49_hold_acc", if0.acc_out, 196);
    chk("w8_acc", if1.acc_out, 38);
    chk("w8_ovf", if1.ovf, 1);
    chk("w8_cnt", if1.cnt_out, 6);
    cyc(0, 0, 0, 1);
    chk("w8_ovf_clr", if1.ovf, 0);
    chk("rel_rdy", if0.in_ready, 1);
    cyc(1, 5, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(0, 0, 1, 0);
    chk("fl_acc", if0.acc_out, 12);
    chk("fl_cnt", if0.cnt_out, 2);
    chk("fl_vld", if0.out_valid, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("fl_empty", if0.out_valid, 0);
    cyc(1, 5, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 9, 1, 0);
    chk("fla_acc", if0.acc_out, 21);
    chk("fla_cnt", if0.cnt_out, 3);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 4, 0, 0);
    repeat (5) cyc(1, 63, 0, 0);
    chk("bp_rdy", if0.in_ready, 0);
    chk("bp_acc", if0.acc_out, 10);
    chk("bp_cnt", if0.cnt_out, 4);
    cyc(0, 0, 0, 1);
    chk("bp_next", if0.acc_out, 0);
    cyc(1, 3, 0, 1);
    cyc(1, 4, 1, 1);
    cyc(0, 0, 0, 1);
    chk("early_rdy", if0.out_valid, 0);
    cyc(1, 10, 0, 0);
    cyc(1, 20, 0, 0);
    chk("pre_rst_acc", if0.acc_out, 30);
    #2 rst = 1;
    #1;
    chk("arst_acc", if0.acc_out, 0);
    chk("arst_cnt", if0.cnt_out, 0);
    chk("arst_rdy", if0.in_ready, 1);
    chk("arst_acc1", if1.acc_out, 0);
    in_valid = 0;
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 4, 0, 0);
    chk("post_rst_acc", if0.acc_out, 10);
    chk("post_rst_vld", if0.out_valid, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
